// File: rtl/memrequest_pkg.sv
// Shared types and default bus widths for the memrequest responder slice.
package memrequest_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_REFRESH
  } state_t;

endpackage

// File: rtl/memrequest_if.sv
// Pipelined memrequest bus between an initiator (master) and the responder (slave).
interface memrequest_if
  import memrequest_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              memrequest_en;
  logic              memrequest_write_enable;
  logic [ADDR_W-1:0] memrequest_addr;
  logic [DATA_W-1:0] memrequest_write_data;
  logic              memrequest_busy;
  logic              memrequest_complete;
  logic [DATA_W-1:0] memrequest_resp_data;

  modport master (
    output memrequest_en,
    output memrequest_write_enable,
    output memrequest_addr,
    output memrequest_write_data,
    input  memrequest_busy,
    input  memrequest_complete,
    input  memrequest_resp_data
  );

  modport slave (
    input  memrequest_en,
    input  memrequest_write_enable,
    input  memrequest_addr,
    input  memrequest_write_data,
    output memrequest_busy,
    output memrequest_complete,
    output memrequest_resp_data
  );

endinterface

// File: rtl/memrequest_delay_line.sv
// Fixed-depth response pipeline; tail data only advances behind a valid entry,
// so the tail holds the most recent response between acks.
module memrequest_delay_line #(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              tail_valid,
  output logic [DATA_W-1:0] tail_data
);

  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      valid <= {valid[DEPTH-2:0], push_valid};
      if (push_valid) begin
        data[0] <= push_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (valid[i-1]) begin
          data[i] <= data[i-1];
        end
      end
    end
  end

  assign tail_valid = valid[DEPTH-1];
  assign tail_data  = data[DEPTH-1];

endmodule

// File: rtl/memrequest_responder.sv
// RAM-backed stand-in for the DDR3 controller on the memrequest bus, with
// calibration busy, periodic refresh stalls, fixed latency and an outstanding cap.
module memrequest_responder
  import memrequest_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MEM_AW          = 12,
  parameter int LATENCY         = 6,
  parameter int MAX_OUTSTANDING = 4,
  parameter int INIT_CYCLES     = 64,
  parameter int REFRESH_PERIOD  = 512,
  parameter int REFRESH_CYCLES  = 16
) (
  input logic         clk,
  input logic         rst_n,
  memrequest_if.slave bus
);

  localparam int TIMER_W = $clog2((INIT_CYCLES > REFRESH_CYCLES ? INIT_CYCLES : REFRESH_CYCLES) + 1);
  localparam int REF_W   = $clog2((REFRESH_PERIOD > 2 ? REFRESH_PERIOD : 2) + 1);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [REF_W-1:0]   refresh_cnt;
  logic [OUT_W-1:0]   outstanding;
  logic [DATA_W-1:0]  mem [2**MEM_AW];

  logic [ADDR_W-1:0]  addr;
  logic [MEM_AW-1:0]  mem_idx;
  logic               unused_addr_bits;
  logic               busy;
  logic               accept;
  logic               ack;
  logic [DATA_W-1:0]  push_data;
  logic [DATA_W-1:0]  resp_data;

  // Upper address bits alias onto the same RAM word.
  assign addr             = bus.memrequest_addr;
  assign mem_idx          = addr[MEM_AW-1:0];
  assign unused_addr_bits = ^addr[ADDR_W-1:MEM_AW];

  assign busy      = (state != ST_RUN) || (outstanding == OUT_W'(MAX_OUTSTANDING));
  assign accept    = bus.memrequest_en && !busy;
  assign push_data = bus.memrequest_write_enable ? '0 : mem[mem_idx];

  assign bus.memrequest_busy      = busy;
  assign bus.memrequest_complete  = ack;
  assign bus.memrequest_resp_data = resp_data;

  always_ff @(posedge clk) begin
    if (accept && bus.memrequest_write_enable) begin
      mem[mem_idx] <= bus.memrequest_write_data;
    end
  end

  // One shared timer covers both calibration and refresh busy windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      timer       <= '0;
      refresh_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (timer == TIMER_W'(INIT_CYCLES - 1)) begin
            timer <= '0;
            state <= ST_RUN;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        ST_RUN: begin
          if (REFRESH_PERIOD != 0) begin
            if (refresh_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
              state <= ST_DRAIN;
            end else begin
              refresh_cnt <= refresh_cnt + REF_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            state <= ST_REFRESH;
          end
        end
        ST_REFRESH: begin
          if (timer == TIMER_W'(REFRESH_CYCLES - 1)) begin
            timer       <= '0;
            refresh_cnt <= '0;
            state       <= ST_RUN;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (accept && !ack) begin
      assert (outstanding < OUT_W'(MAX_OUTSTANDING));
      outstanding <= outstanding + OUT_W'(1);
    end else if (ack && !accept) begin
      assert (outstanding != '0);
      outstanding <= outstanding - OUT_W'(1);
    end
  end

  memrequest_delay_line #(
    .DEPTH  (LATENCY),
    .DATA_W (DATA_W)
  ) u_delay_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (accept),
    .push_data  (push_data),
    .tail_valid (ack),
    .tail_data  (resp_data)
  );

endmodule

// File: tb/tb_memrequest_responder.sv
// Randomized bench for memrequest_responder against a timestamp-based model of
// the controller (ack due times, RAM array, refresh windows).
module tb_memrequest_responder;
  import memrequest_pkg::*;

  localparam int ADDR_W          = 24;
  localparam int DATA_W          = 128;
  localparam int MEM_AW          = 12;
  localparam int LATENCY         = 6;
  localparam int MAX_OUT         = 4;
  localparam int INIT_CYCLES     = 64;
  localparam int REFRESH_PERIOD  = 512;
  localparam int REFRESH_CYCLES  = 16;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;

  memrequest_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memrequest_responder #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .MEM_AW          (MEM_AW),
    .LATENCY         (LATENCY),
    .MAX_OUTSTANDING (MAX_OUT),
    .INIT_CYCLES     (INIT_CYCLES),
    .REFRESH_PERIOD  (REFRESH_PERIOD),
    .REFRESH_CYCLES  (REFRESH_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  req_t              reqQ[$];
  pend_t             pendQ[$];
  logic [DATA_W-1:0] memModel [2**MEM_AW];
  bit                written [2**MEM_AW];
  int                writtenIdx[$];

  int                vectors;
  int                miscompares;
  int                edgeK;
  int                runStart;
  int                holdUntil;
  int                gapPct;
  int                ackCount;
  int                firstAckObs;
  int                firstIdleObs;
  logic [DATA_W-1:0] firstAckData;
  logic [DATA_W-1:0] lastResp;
  bit                presenting;
  req_t              cur;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s @edge %0d: observed %h expected %h", tag, edgeK, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] randWord();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic pushWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    logic [MEM_AW-1:0] idx;
    idx = addr[MEM_AW-1:0];
    if (!written[idx]) begin
      written[idx] = 1'b1;
      writtenIdx.push_back(int'(idx));
    end
    reqQ.push_back('{1'b1, addr, data});
  endtask

  task automatic pushRead(input logic [ADDR_W-1:0] addr);
    reqQ.push_back('{1'b0, addr, '0});
  endtask

  // Writes land in 32..95 so the directed words at 0x005 and 0x010 survive.
  task automatic pushRandom(input int n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-MEM_AW-1:0] hi;
      logic [MEM_AW-1:0]        idx;
      hi = (ADDR_W-MEM_AW)'($urandom());
      if (writtenIdx.size() > 0 && $urandom_range(1) == 1) begin
        idx = MEM_AW'(writtenIdx[$urandom_range(writtenIdx.size() - 1)]);
        pushRead({hi, idx});
      end else begin
        idx = MEM_AW'(32 + $urandom_range(63));
        pushWrite({hi, idx}, randWord());
      end
    end
  endtask

  // A presented request is held until the model says it was accepted.
  task automatic applyStimulus(input bit expBusy);
    logic [MEM_AW-1:0] idx;
    logic [DATA_W-1:0] rdata;
    if (!presenting && reqQ.size() > 0 && $urandom_range(99) >= gapPct) begin
      cur        = reqQ.pop_front();
      presenting = 1'b1;
    end
    if (presenting) begin
      bus.memrequest_en           = 1'b1;
      bus.memrequest_write_enable = cur.we;
      bus.memrequest_addr         = cur.addr;
      bus.memrequest_write_data   = cur.data;
      if (!expBusy) begin
        idx   = cur.addr[MEM_AW-1:0];
        rdata = cur.we ? '0 : memModel[idx];
        if (cur.we) memModel[idx] = cur.data;
        pendQ.push_back('{edgeK + LATENCY, rdata});
        presenting = 1'b0;
      end
    end else begin
      bus.memrequest_en           = 1'b0;
      bus.memrequest_write_enable = 1'($urandom());
      bus.memrequest_addr         = ADDR_W'($urandom());
      bus.memrequest_write_data   = randWord();
    end
  endtask

  // Called at a negedge; checks what the DUT shows ahead of posedge edgeK.
  task automatic stepCycle();
    int outst;
    bit expComplete;
    bit expBusy;
    outst       = pendQ.size();
    expComplete = 1'b0;
    if (outst > 0) expComplete = (pendQ[0].due == edgeK);
    if (bus.memrequest_complete === 1'b1) begin
      ackCount++;
      if (firstAckObs < 0) begin
        firstAckObs  = edgeK;
        firstAckData = bus.memrequest_resp_data;
      end
    end
    if (bus.memrequest_busy === 1'b0 && firstIdleObs < 0) firstIdleObs = edgeK;
    checkOutput("complete", DATA_W'(bus.memrequest_complete), DATA_W'(expComplete));
    if (expComplete) begin
      lastResp = pendQ[0].data;
      void'(pendQ.pop_front());
    end
    checkOutput("resp_data", bus.memrequest_resp_data, lastResp);
    if (edgeK < INIT_CYCLES) begin
      expBusy = 1'b1;
    end else if (edgeK < holdUntil) begin
      expBusy = 1'b1;
    end else if (REFRESH_PERIOD != 0 && edgeK >= runStart + REFRESH_PERIOD) begin
      expBusy = 1'b1;
      if (outst == 0) begin
        holdUntil = edgeK + REFRESH_CYCLES + 1;
        runStart  = holdUntil;
      end
    end else begin
      expBusy = (outst == MAX_OUT);
    end
    checkOutput("busy", DATA_W'(bus.memrequest_busy), DATA_W'(expBusy));
    applyStimulus(expBusy);
    @(posedge clk);
    edgeK++;
    @(negedge clk);
  endtask

  task automatic runUntilIdle(input int limit);
    int n;
    n = 0;
    while ((reqQ.size() > 0 || presenting || pendQ.size() > 0) && n < limit) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_idle", DATA_W'(reqQ.size() + pendQ.size() + int'(presenting)), '0);
  endtask

  task automatic checkReset();
    checkOutput("rst_busy", DATA_W'(bus.memrequest_busy), DATA_W'(1));
    checkOutput("rst_complete", DATA_W'(bus.memrequest_complete), '0);
    checkOutput("rst_resp_data", bus.memrequest_resp_data, '0);
  endtask

  task automatic releaseReset();
    rst_n        = 1'b1;
    edgeK        = 0;
    runStart     = INIT_CYCLES;
    holdUntil    = 0;
    lastResp     = '0;
    firstAckObs  = -1;
    firstIdleObs = -1;
  endtask

  initial begin
    logic [DATA_W-1:0] aliasWord;
    int                ackBase;
    int                n;
    vectors     = 0;
    miscompares = 0;
    ackCount    = 0;
    gapPct      = 0;
    presenting  = 1'b0;
    rst_n       = 1'b0;
    bus.memrequest_en           = 1'b0;
    bus.memrequest_write_enable = 1'b0;
    bus.memrequest_addr         = '0;
    bus.memrequest_write_data   = '0;
    repeat (3) begin
      @(negedge clk);
      checkReset();
    end
    releaseReset();

    // Request presented from cycle 0: calibration window, then write/read pair.
    pushWrite(24'h000010, {16{8'hA5}});
    pushRead(24'h000010);
    runUntilIdle(200);
    checkOutput("init_busy_cycles", DATA_W'(firstIdleObs), DATA_W'(INIT_CYCLES));
    checkOutput("first_ack_cycle", DATA_W'(firstAckObs), DATA_W'(INIT_CYCLES + LATENCY));
    checkOutput("first_ack_write_data", firstAckData, '0);
    checkOutput("pair_ack_count", DATA_W'(ackCount), DATA_W'(2));

    aliasWord = randWord();
    pushWrite(24'h001005, aliasWord);
    pushRead(24'h000005);
    runUntilIdle(100);
    checkOutput("alias_read", lastResp, aliasWord);

    ackBase = ackCount;
    for (int i = 0; i < 10; i++) begin
      pushRead(ADDR_W'(writtenIdx[$urandom_range(writtenIdx.size() - 1)]));
    end
    runUntilIdle(200);
    checkOutput("b2b_ack_count", DATA_W'(ackCount - ackBase), DATA_W'(10));

    gapPct = 40;
    pushRandom(150);
    runUntilIdle(3000);

    // Saturated traffic across the first refresh window.
    gapPct = 0;
    while (edgeK < 660) begin
      if (reqQ.size() < 4) pushRandom(4);
      stepCycle();
    end
    runUntilIdle(200);

    // Reset with reads in flight: they must never be acked.
    pushRead(24'h000010);
    pushRead(24'h001005);
    pushRead(24'h000010);
    pushRead(24'h000005);
    n = 0;
    while (pendQ.size() < 3 && n < 60) begin
      stepCycle();
      n++;
    end
    checkOutput("inflight_before_reset", DATA_W'(pendQ.size() >= 3), DATA_W'(1));
    rst_n      = 1'b0;
    presenting = 1'b0;
    reqQ.delete();
    pendQ.delete();
    bus.memrequest_en = 1'b0;
    #1;
    checkReset();
    repeat (2) begin
      @(negedge clk);
      checkReset();
    end
    @(negedge clk);
    releaseReset();

    pushRead(24'h000010);
    pushRead(24'hABC005);
    gapPct = 20;
    pushRandom(20);
    runUntilIdle(400);
    checkOutput("reinit_busy_cycles", DATA_W'(firstIdleObs), DATA_W'(INIT_CYCLES));
    checkOutput("reinit_first_ack_cycle", DATA_W'(firstAckObs), DATA_W'(INIT_CYCLES + LATENCY));
    checkOutput("reinit_read_0x10", firstAckData, {16{8'hA5}});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
